puf_response_collector: RTL
===========================

# puf_response_collector

Sequencer that sits beside the ring-oscillator PUF top level. It drives that block's challenge pair and enable, consumes its single-bit Response/Done/Busy outputs, and assembles N_BITS successive comparisons into one response word. It walks a seed-derived challenge schedule and guards every measurement with a watchdog. It is the block the system-level host or UART bridge talks to when it needs a full PUF response.

## Interface

Parameters:
- N_BITS, default 16: response word width (2..64).
- TIMEOUT_CYCLES, default 131072: maximum cycles allowed per wait state (ARM or RELEASE).

Ports (the block uses one clock; reset is asynchronous and active-low):
- CLK  in  1  system clock, the same clock as the PUF top level.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  request a new response word; sampled only in IDLE.
- SEED  in  6  challenge schedule seed; [2:0] is the base for RO group 0, [5:3] the base for RO group 1.
- PUF_EN  out  1  to PUF EN.
- CHALLENGE_0  out  3  to PUF challenge_0.
- CHALLENGE_1  out  3  to PUF challenge_1.
- PUF_RESPONSE  in  1  from PUF Response.
- PUF_DONE  in  1  from PUF Done.
- PUF_BUSY  in  1  from PUF Busy.
- RESPONSE  out  N_BITS  assembled word; bit i is the result of measurement i.
- VALID  out  1  RESPONSE holds a complete word.
- BUSY  out  1  a collection is in progress.
- ERR  out  1  a collection was aborted because of a bad seed or a timeout.

## Operation

- States: IDLE, SETUP, ARM, RELEASE, FINISH, ERROR.
- IDLE:
  - START=1 with SEED[2:0]≠SEED[5:3]: clear VALID, ERR and the bit index i; go to SETUP.
  - START=1 with SEED[2:0]=SEED[5:3]: go to ERROR.
  - START=0: stay in IDLE.
- SETUP:
  - Drive CHALLENGE_0 = (SEED[2:0]+i) mod 8 and CHALLENGE_1 = (SEED[5:3]+i) mod 8, 3-bit wrap.
  - These are distinct for every i because the difference is constant. They are registered and held stable through ARM and RELEASE.
  - Go to ARM.
- ARM:
  - PUF_EN=1.
  - The first cycle with PUF_DONE=1 shifts PUF_RESPONSE into shadow bit i and moves to RELEASE.
- RELEASE:
  - PUF_EN=0.
  - Wait until PUF_DONE=0 and PUF_BUSY=0 in the same cycle.
  - If i=N_BITS-1, go to FINISH; otherwise i←i+1 and go to SETUP.
- FINISH: RESPONSE←shadow, VALID=1, go to IDLE. VALID stays high until the next accepted START.
- Watchdog:
  - Counts cycles spent in ARM or RELEASE and reloads on every state entry.
  - When the count reaches TIMEOUT_CYCLES, go to ERROR.
- ERROR:
  - PUF_EN=0, ERR=1, BUSY=0, VALID=0; RESPONSE is unchanged.
  - Next cycle go to IDLE with ERR held until the next accepted START.
- BUSY=1 in SETUP, ARM, RELEASE and FINISH.
- START while BUSY=1 is ignored, with no queuing.
- Reset mid-collection:
  - Every output goes to 0 immediately, including PUF_EN, so the PUF controller sees its master enable drop.
  - The shadow register and i are cleared.

## Timing

- Reset values: PUF_EN=0, CHALLENGE_0=0, CHALLENGE_1=0, RESPONSE=0, VALID=0, BUSY=0, ERR=0, state=IDLE.
- START high at edge t:
  - BUSY=1 and the challenges are valid after t+1.
  - PUF_EN=1 after t+2, so the challenges lead PUF_EN by one cycle.
- PUF_DONE first high at edge d: bit captured at d, PUF_EN=0 after d+1.
- PUF_DONE and PUF_BUSY both low at edge r:
  - For the next bit, the challenges update after r+1 and PUF_EN=1 after r+2.
  - For the last bit, VALID=1, BUSY=0 and the RESPONSE update all appear after r+2 (one cycle in FINISH).
- Block overhead is 4 cycles per bit plus the PUF measurement time.
- Bad seed: ERR=1 after t+2; BUSY is never asserted.
- Timeout: ERR=1 two cycles after the count reaches TIMEOUT_CYCLES.
- Simultaneous START and reset: reset wins.

## Structure

- Package puf_collector_pkg holds:
  - the state enum;
  - the default N_BITS and TIMEOUT_CYCLES;
  - the watchdog width, $clog2(TIMEOUT_CYCLES+1);
  - the CHAL_W=3 constant.
- One sub-module, puf_watchdog:
  - Inputs: reload and count enable.
  - Output: an expired flag.
  - Clocked on CLK/RST_N.
- Datapath in the top module: the FSM, the index counter, the challenge registers, the shadow shift register and the output register.

## Test plan

The bench drives a behavioural PUF model with a programmable Done latency and a table of Response bits per challenge pair.

- Basic collection: SEED=6'o10, N_BITS=16, model returns 1 when CHALLENGE_0 is even.
  - Expected: RESPONSE=16'h5555, VALID=1 and ERR=0.
  - CHALLENGE_0 must sequence 0..7,0..7 and CHALLENGE_1 must sequence 1..7,0,1..7,0.
- Bad seed: SEED=6'o33 with START.
  - Expected: ERR=1 after 2 cycles, BUSY never asserted, PUF_EN never asserted.
- Timeout: model never raises Done, TIMEOUT_CYCLES=64.
  - Expected: ERR=1 with PUF_EN=0 at the expected cycle.
  - Then restart with a good seed: ERR clears and the word completes.
- Handshake: model holds Busy high 10 cycles after Done falls.
  - Expected: no next PUF_EN until Busy=0.
  - Challenges must change only while PUF_EN=0.
- Reset mid-word: assert RST_N=0 during bit 7 of a collection.
  - Expected: all outputs 0 asynchronously.
  - After release, a fresh START yields the correct full word.
- Ignored START: pulse START during ARM and while VALID=1.
  - Expected: a START during ARM is ignored.
  - A START while VALID=1 clears VALID and starts a new collection.

Source files
------------

// File: rtl/puf_collector_pkg.sv
// Shared types and constants for the ring-oscillator PUF response collector.
package puf_collector_pkg;

  localparam int unsigned DefaultNBits         = 16;
  localparam int unsigned DefaultTimeoutCycles = 131072;
  localparam int unsigned WdWidth              = $clog2(DefaultTimeoutCycles + 1);
  localparam int unsigned ChalW                = 3;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StArm,
    StRelease,
    StFinish,
    StError
  } state_e;

  // Challenge for measurement idx: the group base offset by idx, wrapping modulo 2**ChalW.
  function automatic logic [ChalW-1:0] chal_at(input logic [ChalW-1:0] base,
                                               input logic [ChalW-1:0] idx);
    return base + idx;
  endfunction

endpackage

// File: rtl/puf_watchdog.sv
// Per-state cycle watchdog: reloads on state entry, counts while enabled.
module puf_watchdog
  import puf_collector_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles,
  parameter int unsigned CntW           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic reload_i,
  input  logic count_en_i,
  output logic expired_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  // High on the edge at which the count reaches TIMEOUT_CYCLES.
  assign expired_o = count_en_i && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (reload_i) begin
      cnt_d = '0;
    end else if (count_en_i && !expired_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/puf_response_collector.sv
// Sequences N_BITS ring-oscillator PUF comparisons over a seed-derived challenge
// schedule and assembles them into one response word.
module puf_response_collector
  import puf_collector_pkg::*;
#(
  parameter int unsigned N_BITS         = DefaultNBits,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [5:0]        seed_i,
  output logic              puf_en_o,
  output logic [ChalW-1:0]  challenge_0_o,
  output logic [ChalW-1:0]  challenge_1_o,
  input  logic              puf_response_i,
  input  logic              puf_done_i,
  input  logic              puf_busy_i,
  output logic [N_BITS-1:0] response_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned IdxW = ($clog2(N_BITS) > ChalW) ? $clog2(N_BITS) : ChalW;
  localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_q, state_d;
  logic [5:0]        seed_q;
  logic [IdxW-1:0]   idx_q;
  logic [N_BITS-1:0] shadow_q;
  logic [N_BITS-1:0] response_q;
  logic [ChalW-1:0]  chal0_q, chal1_q;
  logic              puf_en_q, busy_q, valid_q, err_q;
  logic              fin_q, err_hit_q;
  logic              wd_en, wd_reload, wd_expired;
  logic              start_ok, seed_bad, last_bit;

  assign seed_bad  = (seed_i[2:0] == seed_i[5:3]);
  assign start_ok  = (state_q == StIdle) && start_i && !seed_bad;
  assign last_bit  = (idx_q == IdxW'(N_BITS - 1));
  assign wd_en     = (state_q == StArm) || (state_q == StRelease);
  assign wd_reload = (state_d != state_q);

  puf_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CntW          (WdW)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .reload_i  (wd_reload),
    .count_en_i(wd_en),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = seed_bad ? StError : StSetup;
      end
      StSetup: state_d = StArm;
      StArm: begin
        if (wd_expired)      state_d = StError;
        else if (puf_done_i) state_d = StRelease;
      end
      StRelease: begin
        if (wd_expired)                      state_d = StError;
        else if (!puf_done_i && !puf_busy_i) state_d = last_bit ? StFinish : StSetup;
      end
      StFinish: state_d = StIdle;
      StError:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      seed_q     <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      response_q <= '0;
      chal0_q    <= '0;
      chal1_q    <= '0;
      puf_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      fin_q      <= 1'b0;
      err_hit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      // Outputs are registered decodes of the current state, one cycle behind it.
      puf_en_q  <= (state_q == StArm);
      busy_q    <= (state_q == StSetup) || (state_q == StArm) ||
                   (state_q == StRelease) || (state_q == StFinish);
      fin_q     <= (state_q == StFinish);
      err_hit_q <= (state_q == StError);

      if (fin_q) begin
        response_q <= shadow_q;
        valid_q    <= 1'b1;
      end
      if (err_hit_q) begin
        err_q   <= 1'b1;
        valid_q <= 1'b0;
      end
      // A newly accepted request overrides any status update landing on the same edge.
      if (start_ok) begin
        seed_q   <= seed_i;
        idx_q    <= '0;
        shadow_q <= '0;
        valid_q  <= 1'b0;
        err_q    <= 1'b0;
      end

      if (state_q == StSetup) begin
        chal0_q <= chal_at(seed_q[2:0], idx_q[ChalW-1:0]);
        chal1_q <= chal_at(seed_q[5:3], idx_q[ChalW-1:0]);
      end
      if ((state_q == StArm) && (state_d == StRelease)) begin
        shadow_q[idx_q] <= puf_response_i;
      end
      if ((state_q == StRelease) && (state_d == StSetup)) begin
        idx_q <= idx_q + IdxW'(1);
      end
    end
  end

  assign puf_en_o      = puf_en_q;
  assign challenge_0_o = chal0_q;
  assign challenge_1_o = chal1_q;
  assign response_o    = response_q;
  assign valid_o       = valid_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;

endmodule
